seg7_scan_decoder: RTL and testbench

Reads back a multiplexed, active-low seven-segment display bus: per-digit anode strobes plus shared segment lines. It reconstructs the hex nibble shown on each digit. It sits on the display side of the hex-to-seven-segment encoder, either as a self-check monitor in the design or as a loopback checker on the board. Each digit's value is committed only after its segment pattern has been stable for a programmable number of cycles.

---
 rtl/seg7_pkg.sv | 42 ++++
 rtl/seg7_scan_decoder_if.sv | 25 ++
 rtl/seg7_pattern_decode.sv | 41 ++++
 rtl/seg7_scan_decoder.sv | 171 +++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: segment pattern constants, scan states and anode helper.
// Shared by the seven-segment readback decoder and its encoder peer.
package seg7_pkg;

  // Active-low segment patterns, bit6=a ... bit0=g
  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0001100;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b1100000;
  localparam logic [6:0] SEG_C = 7'b0110001;
  localparam logic [6:0] SEG_D = 7'b1000010;
  localparam logic [6:0] SEG_E = 7'b0110000;
  localparam logic [6:0] SEG_F = 7'b0111000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HELD   = 2'd2
  } scan_state_e;

  // Number of low (active) bits in an 8-bit anode word
  function automatic logic [3:0] count_low(
    input logic [7:0] an
  );
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, ~an[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// seg7_scan_decoder_if: display bus in (Leds, Anodes) and decoded
// results out (HexVals, DigitValid, DigitErr, Update, Collision).
interface seg7_scan_decoder_if #(
  parameter int NUM_DIGITS = 4
);
  logic [6:0]              Leds;
  logic [NUM_DIGITS-1:0]   Anodes;
  logic [4*NUM_DIGITS-1:0] HexVals;
  logic [NUM_DIGITS-1:0]   DigitValid;
  logic [NUM_DIGITS-1:0]   DigitErr;
  logic                    Update;
  logic                    Collision;

  modport master (
    output Leds, Anodes,
    input  HexVals, DigitValid, DigitErr,
    input  Update, Collision
  );

  modport slave (
    input  Leds, Anodes,
    output HexVals, DigitValid, DigitErr,
    output Update, Collision
  );
endinterface

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: combinational segment pattern to nibble lookup.
// i_leds in; o_known, o_blank, o_nib out.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] i_leds,
  output logic       o_known,
  output logic       o_blank,
  output logic [3:0] o_nib
);

  always_comb begin
    o_known = 1'b1;
    o_blank = 1'b0;
    o_nib   = 4'h0;
    unique case (i_leds)
      SEG_0: o_nib = 4'h0;
      SEG_1: o_nib = 4'h1;
      SEG_2: o_nib = 4'h2;
      SEG_3: o_nib = 4'h3;
      SEG_4: o_nib = 4'h4;
      SEG_5: o_nib = 4'h5;
      SEG_6: o_nib = 4'h6;
      SEG_7: o_nib = 4'h7;
      SEG_8: o_nib = 4'h8;
      SEG_9: o_nib = 4'h9;
      SEG_A: o_nib = 4'hA;
      SEG_B: o_nib = 4'hB;
      SEG_C: o_nib = 4'hC;
      SEG_D: o_nib = 4'hD;
      SEG_E: o_nib = 4'hE;
      SEG_F: o_nib = 4'hF;
      SEG_BLANK: begin
        o_known = 1'b0;
        o_blank = 1'b1;
      end
      default: o_known = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: reads back a muxed active-low 7-seg bus.
// Clk, Reset_n; bus.slave carries Leds/Anodes in, results out.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic Clk,
  input  logic Reset_n,
  seg7_scan_decoder_if.slave bus
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int SW = NUM_DIGITS + 7;
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CONE = CW'(1);

  logic [SW-1:0]           r_samp;
  logic [SW-1:0]           r_prev;
  scan_state_e             r_state;
  logic [CW-1:0]           r_cnt;
  logic [4*NUM_DIGITS-1:0] r_hex;
  logic [NUM_DIGITS-1:0]   r_valid;
  logic [NUM_DIGITS-1:0]   r_err;
  logic                    r_upd;
  logic                    r_coll;

  logic [NUM_DIGITS-1:0]   w_an;
  logic [6:0]              w_leds;
  logic [7:0]              w_an8;
  logic [3:0]              w_nlow;
  logic                    w_one;
  logic                    w_multi;
  logic                    w_same;
  logic                    w_known;
  logic                    w_blank;
  logic [3:0]              w_nib;
  scan_state_e             w_state_n;
  scan_state_e             w_st_start;
  logic [CW-1:0]           w_cnt_n;
  logic [CW-1:0]           w_cnt_start;
  logic                    w_commit;
  logic [4*NUM_DIGITS-1:0] w_hex_n;
  logic [NUM_DIGITS-1:0]   w_valid_n;
  logic [NUM_DIGITS-1:0]   w_err_n;
  logic                    w_chg;

  assign w_an   = r_samp[SW-1:7];
  assign w_leds = r_samp[6:0];

  seg7_pattern_decode u_dec (
    .i_leds  (w_leds),
    .o_known (w_known),
    .o_blank (w_blank),
    .o_nib   (w_nib)
  );

  always_comb begin
    w_an8 = '1;
    w_an8[NUM_DIGITS-1:0] = w_an;
    w_nlow  = count_low(w_an8);
    w_one   = (w_nlow == 4'd1);
    w_multi = (w_nlow > 4'd1);
    w_same  = (r_samp == r_prev);
  end

  // Fresh evaluation of the current sample, as if from IDLE
  always_comb begin
    if (w_one) begin
      w_st_start  = ST_SETTLE;
      w_cnt_start = CONE;
    end else begin
      w_st_start  = ST_IDLE;
      w_cnt_start = '0;
    end
  end

  // A commit needs STABLE_CYCLES+1 identical samples: the
  // counter reaches its limit first, the next match commits.
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_commit  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_state_n = w_st_start;
        w_cnt_n   = w_cnt_start;
      end
      ST_SETTLE: begin
        if (!w_same) begin
          w_state_n = w_st_start;
          w_cnt_n   = w_cnt_start;
        end else if (r_cnt == CMAX) begin
          w_commit  = 1'b1;
          w_state_n = ST_HELD;
        end else begin
          w_cnt_n = r_cnt + CONE;
        end
      end
      ST_HELD: begin
        if (!w_same) begin
          w_state_n = w_st_start;
          w_cnt_n   = w_cnt_start;
        end
      end
      default: begin
        w_state_n = ST_IDLE;
        w_cnt_n   = '0;
      end
    endcase
  end

  // Only the single active digit is touched on a commit
  always_comb begin
    w_hex_n   = r_hex;
    w_valid_n = r_valid;
    w_err_n   = r_err;
    if (w_commit) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (!w_an[i]) begin
          if (w_known) begin
            w_hex_n[4*i +: 4] = w_nib;
            w_valid_n[i] = 1'b1;
            w_err_n[i]   = 1'b0;
          end else if (w_blank) begin
            w_valid_n[i] = 1'b0;
            w_err_n[i]   = 1'b0;
          end else begin
            w_valid_n[i] = 1'b0;
            w_err_n[i]   = 1'b1;
          end
        end
      end
    end
    w_chg = ({w_hex_n, w_valid_n, w_err_n}
          != {r_hex, r_valid, r_err});
  end

  // Sample regs reset to idle bus so reset is no collision
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_samp  <= '1;
      r_prev  <= '1;
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_hex   <= '0;
      r_valid <= '0;
      r_err   <= '0;
      r_upd   <= 1'b0;
      r_coll  <= 1'b0;
    end else begin
      r_samp  <= {bus.Anodes, bus.Leds};
      r_prev  <= r_samp;
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_hex   <= w_hex_n;
      r_valid <= w_valid_n;
      r_err   <= w_err_n;
      r_upd   <= w_chg;
      r_coll  <= w_multi;
    end
  end

  assign bus.HexVals    = r_hex;
  assign bus.DigitValid = r_valid;
  assign bus.DigitErr   = r_err;
  assign bus.Update     = r_upd;
  assign bus.Collision  = r_coll;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: directed checks of the 7-seg readback decoder.
// Drives strobes on negedges, samples outputs on negedges.
module tb_seg7_scan_decoder;
  import seg7_pkg::*;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  int total = 0;
  int bad = 0;
  int n_upd = 0;
  int n_coll = 0;
  int u0;
  int c0;
  logic [6:0] pats [16];

  seg7_scan_decoder_if #(.NUM_DIGITS(4)) bus ();

  seg7_scan_decoder #(
    .NUM_DIGITS    (4),
    .STABLE_CYCLES (4)
  ) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (bus.Update === 1'b1) n_upd++;
    if (bus.Collision === 1'b1) n_coll++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] an,
                       input logic [6:0] l,
                       input int n);
    bus.Anodes = an;
    bus.Leds   = l;
    repeat (n) @(negedge Clk);
  endtask

  task automatic idle();
    drive(4'b1111, SEG_BLANK, 8);
  endtask

  task automatic mark();
    u0 = n_upd;
    c0 = n_coll;
  endtask

  initial begin
    pats = '{SEG_0, SEG_1, SEG_2, SEG_3,
             SEG_4, SEG_5, SEG_6, SEG_7,
             SEG_8, SEG_9, SEG_A, SEG_B,
             SEG_C, SEG_D, SEG_E, SEG_F};
    bus.Anodes = 4'b1111;
    bus.Leds   = SEG_BLANK;
    repeat (2) @(negedge Clk);
    chk("rst_hex", 32'(bus.HexVals), 32'h0);
    chk("rst_valid", 32'(bus.DigitValid), 32'h0);
    chk("rst_err", 32'(bus.DigitErr), 32'h0);
    chk("rst_upd", 32'(bus.Update), 32'h0);
    chk("rst_coll", 32'(bus.Collision), 32'h0);
    Reset_n = 1'b1;
    idle();
    chk("post_rst_upd", 32'(n_upd), 32'd0);

    // digit 0 shows 2 for five cycles
    mark();
    drive(4'b1110, SEG_2, 5);
    idle();
    chk("d0_hex", 32'(bus.HexVals[3:0]), 32'h2);
    chk("d0_valid", 32'(bus.DigitValid), 32'b0001);
    chk("d0_upd", 32'(n_upd - u0), 32'd1);

    // all 16 patterns on digit 3
    for (int k = 0; k < 16; k++) begin
      mark();
      drive(4'b0111, pats[k], 5);
      idle();
      chk("sweep_hex", 32'(bus.HexVals[15:12]), 32'(k));
      chk("sweep_valid", 32'(bus.DigitValid[3]), 32'd1);
      chk("sweep_upd", 32'(n_upd - u0), 32'd1);
    end

    // 4-cycle strobe must not commit
    mark();
    drive(4'b1101, SEG_3, 4);
    idle();
    chk("short_valid", 32'(bus.DigitValid[1]), 32'd0);
    chk("short_upd", 32'(n_upd - u0), 32'd0);
    mark();
    drive(4'b1101, SEG_3, 5);
    idle();
    chk("d1_hex", 32'(bus.HexVals[7:4]), 32'h3);
    chk("d1_valid", 32'(bus.DigitValid[1]), 32'd1);
    chk("d1_upd", 32'(n_upd - u0), 32'd1);
    mark();
    drive(4'b1101, SEG_3, 5);
    idle();
    chk("rescan_upd", 32'(n_upd - u0), 32'd0);
    chk("rescan_hex", 32'(bus.HexVals[7:4]), 32'h3);

    // collision aborts a nearly complete settle
    mark();
    drive(4'b0111, SEG_9, 4);
    drive(4'b1100, SEG_9, 2);
    idle();
    chk("coll_seen", 32'(n_coll != c0), 32'd1);
    chk("coll_upd", 32'(n_upd - u0), 32'd0);
    chk("coll_hex", 32'(bus.HexVals[15:12]), 32'hF);
    mark();
    drive(4'b0111, SEG_5, 5);
    drive(4'b1100, SEG_8, 3);
    drive(4'b0111, SEG_F, 5);
    idle();
    chk("coll2_seen", 32'(n_coll != c0), 32'd1);
    chk("after_coll_hex", 32'(bus.HexVals[15:12]), 32'hF);
    chk("after_coll_upd", 32'(n_upd - u0), 32'd2);

    // back-to-back strobes, no dead cycle
    mark();
    drive(4'b1110, SEG_7, 5);
    drive(4'b1101, SEG_6, 5);
    idle();
    chk("b2b_d0", 32'(bus.HexVals[3:0]), 32'h7);
    chk("b2b_d1", 32'(bus.HexVals[7:4]), 32'h6);
    chk("b2b_upd", 32'(n_upd - u0), 32'd2);

    // unknown pattern on digit 0
    mark();
    drive(4'b1110, 7'b1010101, 5);
    idle();
    chk("unk_err", 32'(bus.DigitErr), 32'b0001);
    chk("unk_valid", 32'(bus.DigitValid[0]), 32'd0);
    chk("unk_hex", 32'(bus.HexVals[3:0]), 32'h7);
    chk("unk_upd", 32'(n_upd - u0), 32'd1);
    drive(4'b1110, SEG_1, 5);
    idle();
    chk("fix_err", 32'(bus.DigitErr), 32'b0000);
    chk("fix_hex", 32'(bus.HexVals[3:0]), 32'h1);
    chk("fix_valid", 32'(bus.DigitValid[0]), 32'd1);

    // blank on a valid digit 2
    drive(4'b1011, SEG_A, 5);
    idle();
    chk("d2_hex", 32'(bus.HexVals[11:8]), 32'hA);
    mark();
    drive(4'b1011, SEG_BLANK, 5);
    idle();
    chk("blank_valid", 32'(bus.DigitValid[2]), 32'd0);
    chk("blank_hex", 32'(bus.HexVals[11:8]), 32'hA);
    chk("blank_err", 32'(bus.DigitErr[2]), 32'd0);
    chk("blank_upd", 32'(n_upd - u0), 32'd1);

    // reset mid-settle discards the partial count
    drive(4'b1110, SEG_4, 3);
    Reset_n = 1'b0;
    #1;
    chk("mrst_hex", 32'(bus.HexVals), 32'h0);
    chk("mrst_valid", 32'(bus.DigitValid), 32'h0);
    chk("mrst_err", 32'(bus.DigitErr), 32'h0);
    @(negedge Clk);
    Reset_n = 1'b1;
    mark();
    drive(4'b1110, SEG_4, 2);
    idle();
    chk("mrst_upd", 32'(n_upd - u0), 32'd0);
    chk("mrst_valid2", 32'(bus.DigitValid), 32'h0);
    mark();
    drive(4'b1110, SEG_4, 5);
    idle();
    chk("fresh_hex", 32'(bus.HexVals[3:0]), 32'h4);
    chk("fresh_valid", 32'(bus.DigitValid), 32'b0001);
    chk("fresh_upd", 32'(n_upd - u0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
